// File: rtl/ram_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_seq_pkg
//  Description : Shared types for the RAM operation sequencer: opcode and
//                FSM state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_seq_pkg;

    localparam int OP_WIDTH = 3;

    // Encodings 5..7 are illegal and answered with an error response.
    typedef enum logic [OP_WIDTH-1:0] {
        OP_WRITE = 3'd0,
        OP_READ  = 3'd1,
        OP_ADD   = 3'd2,
        OP_COPY  = 3'd3,
        OP_FILL  = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        LOOP = 2'd2,
        RESP = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/ram_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ram_op_sequencer
//  Description : Command-driven initiator for a 2R/1W RAM. Executes
//                single-word WRITE/READ/ADD in one cycle and COPY/FILL block
//                operations one word per cycle, then returns one response.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_op_sequencer
    import ram_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [OP_WIDTH-1:0]   cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_a,
    input  logic [ADDR_WIDTH-1:0] cmd_b,
    input  logic [ADDR_WIDTH-1:0] cmd_dst,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] r_addr0,
    output logic [ADDR_WIDTH-1:0] r_addr1,
    input  logic [DATA_WIDTH-1:0] r_data0,
    input  logic [DATA_WIDTH-1:0] r_data1,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  write_enable
);

    state_e                state_q,    state_d;
    logic [OP_WIDTH-1:0]   op_q,       op_d;
    logic [ADDR_WIDTH-1:0] a_q,        a_d;
    logic [ADDR_WIDTH-1:0] b_q,        b_d;
    logic [ADDR_WIDTH-1:0] dst_q,      dst_d;
    logic [DATA_WIDTH-1:0] data_q,     data_d;
    logic [ADDR_WIDTH:0]   len_q,      len_d;
    logic [ADDR_WIDTH:0]   idx_q,      idx_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q,  rsp_err_d;

    logic [DATA_WIDTH-1:0] w_sum;
    logic [ADDR_WIDTH-1:0] w_idx_lo;
    logic                  w_loop_done;

    // Carry out of the ADD is intentionally dropped by the width of w_sum.
    assign w_sum       = r_data0 + r_data1;
    // Low index bits give modulo-depth address wrap for long blocks.
    assign w_idx_lo    = idx_q[ADDR_WIDTH-1:0];
    // The LOOP state spends one final cycle with idx == len and no write.
    assign w_loop_done = (idx_q == len_q);

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

    // Next-state and response computation.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        dst_d      = dst_q;
        data_d     = data_q;
        len_d      = len_q;
        idx_d      = idx_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d      = cmd_op;
                    a_d       = cmd_a;
                    b_d       = cmd_b;
                    dst_d     = cmd_dst;
                    data_d    = cmd_data;
                    len_d     = cmd_len;
                    idx_d     = '0;
                    rsp_err_d = 1'b0;
                    if (cmd_op == OP_COPY || cmd_op == OP_FILL) begin
                        state_d = LOOP;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                state_d = RESP;
                case (op_q)
                    OP_WRITE: rsp_data_d = data_q;
                    OP_READ:  rsp_data_d = r_data0;
                    OP_ADD:   rsp_data_d = w_sum;
                    default: begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                    end
                endcase
            end
            LOOP: begin
                if (w_loop_done) begin
                    state_d    = RESP;
                    rsp_data_d = DATA_WIDTH'(len_q);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM port drive, decoded from state and the registered command.
    always_comb begin
        r_addr0      = '0;
        r_addr1      = '0;
        w_addr       = '0;
        w_data       = '0;
        write_enable = 1'b0;
        case (state_q)
            EXEC: begin
                r_addr0 = a_q;
                r_addr1 = b_q;
                w_addr  = dst_q;
                if (op_q == OP_WRITE) begin
                    write_enable = 1'b1;
                    w_data       = data_q;
                end else if (op_q == OP_ADD) begin
                    write_enable = 1'b1;
                    w_data       = w_sum;
                end
            end
            LOOP: begin
                // Async read of word i sees word i-1 already written, so
                // overlapping ascending copies propagate the pattern.
                r_addr0 = a_q + w_idx_lo;
                if (!w_loop_done) begin
                    write_enable = 1'b1;
                    w_addr       = dst_q + w_idx_lo;
                    w_data       = (op_q == OP_COPY) ? r_data0 : data_q;
                end
            end
            default: ;
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            dst_q      <= '0;
            data_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            dst_q      <= dst_d;
            data_q     <= data_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_op_sequencer
//  Description : Self-checking bench for ram_op_sequencer with a 2R/1W RAM
//                slave, a reference memory model and a response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_op_sequencer;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [AW-1:0] cmd_a;
    logic [AW-1:0] cmd_b;
    logic [AW-1:0] cmd_dst;
    logic [DW-1:0] cmd_data;
    logic [AW:0]   cmd_len;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic [AW-1:0] r_addr0;
    logic [AW-1:0] r_addr1;
    logic [DW-1:0] r_data0;
    logic [DW-1:0] r_data1;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          write_enable;

    ram_op_sequencer #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_dst      (cmd_dst),
        .cmd_data     (cmd_data),
        .cmd_len      (cmd_len),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .r_addr0      (r_addr0),
        .r_addr1      (r_addr1),
        .r_data0      (r_data0),
        .r_data1      (r_data1),
        .w_addr       (w_addr),
        .w_data       (w_data),
        .write_enable (write_enable)
    );

    // 3-port RAM slave: async reads, synchronous write; write addresses logged.
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_q [$];

    assign r_data0 = mem[r_addr0];
    assign r_data1 = mem[r_addr1];

    always @(posedge clk) begin
        if (write_enable) begin
            mem[w_addr] <= w_data;
            wr_q.push_back(w_addr);
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t          sb [$];
    logic [DW-1:0] exp_mem [DEPTH];
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_mem(input string tag);
        for (int k = 0; k < DEPTH; k++) begin
            check_eq($sformatf("%s_mem%0d", tag, k), 32'(mem[k]), 32'(exp_mem[k]));
        end
    endtask

    // Issue one command, model its effect, and check response, latency,
    // write trace and resulting memory contents.
    task automatic do_cmd(input string tag, input logic [2:0] op, input logic [AW-1:0] a,
                          input logic [AW-1:0] b, input logic [AW-1:0] dst,
                          input logic [DW-1:0] data, input logic [AW:0] len, input int hold);
        exp_t          e;
        exp_t          got_e;
        logic [AW-1:0] ea [$];
        logic [AW-1:0] ad;
        logic [AW-1:0] as;
        logic [DW-1:0] held;
        int            exp_lat;
        int            cyc;
        bit            timed_out;

        e.data  = '0;
        e.err   = 1'b0;
        exp_lat = 2;
        case (op)
            3'd0: begin
                exp_mem[dst] = data;
                ea.push_back(dst);
                e.data = data;
            end
            3'd1: e.data = exp_mem[a];
            3'd2: begin
                e.data       = exp_mem[a] + exp_mem[b];
                exp_mem[dst] = e.data;
                ea.push_back(dst);
            end
            3'd3, 3'd4: begin
                for (int i = 0; i < int'(len); i++) begin
                    ad = dst + AW'(i);
                    as = a + AW'(i);
                    exp_mem[ad] = (op == 3'd3) ? exp_mem[as] : data;
                    ea.push_back(ad);
                end
                e.data  = DW'(len);
                exp_lat = int'(len) + 2;
            end
            default: e.err = 1'b1;
        endcase
        sb.push_back(e);

        @(negedge clk);
        check_eq({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        wr_q.delete();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_dst   = dst;
        cmd_data  = data;
        cmd_len   = len;
        @(posedge clk);

        cyc       = 0;
        timed_out = 1'b0;
        while (1) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            cyc++;
            if (rsp_valid) break;
            if (cyc > 60) begin
                timed_out = 1'b1;
                break;
            end
        end
        check_eq({tag, "_rsp_timeout"}, 32'(timed_out), 32'd0);
        check_eq({tag, "_latency"}, 32'(cyc), 32'(exp_lat));

        held = rsp_data;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            check_eq({tag, "_hold_data"}, 32'(rsp_data), 32'(held));
            check_eq({tag, "_hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
            check_eq({tag, "_hold_we"}, 32'(write_enable), 32'd0);
        end

        rsp_ready = 1'b1;
        got_e = sb.pop_front();
        check_eq({tag, "_rsp_data"}, 32'(rsp_data), 32'(got_e.data));
        check_eq({tag, "_rsp_err"}, 32'(rsp_err), 32'(got_e.err));
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq({tag, "_rsp_valid_drop"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_cmd_ready_back"}, 32'(cmd_ready), 32'd1);

        check_eq({tag, "_wr_count"}, 32'(wr_q.size()), 32'(ea.size()));
        for (int i = 0; i < ea.size() && i < wr_q.size(); i++) begin
            check_eq($sformatf("%s_wr_addr%0d", tag, i), 32'(wr_q[i]), 32'(ea[i]));
        end
        check_mem(tag);
    endtask

    initial begin
        int cyc;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_dst   = '0;
        cmd_data  = '0;
        cmd_len   = '0;
        rsp_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) exp_mem[k] = '0;

        repeat (3) @(negedge clk);
        check_eq("rst_we", 32'(write_enable), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
        check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_addrs", {r_addr0, r_addr1, w_addr}, 32'd0);
        check_eq("rst_w_data", 32'(w_data), 32'd0);
        rst_n = 1'b1;

        // Clear the RAM through the DUT so the model starts from known data.
        do_cmd("init_fill", 3'd4, 3'd0, 3'd0, 3'd0, 8'h00, 4'd8, 0);

        do_cmd("write5", 3'd0, 3'd0, 3'd0, 3'd5, 8'hA5, 4'd0, 0);
        do_cmd("read5",  3'd1, 3'd5, 3'd0, 3'd0, 8'h00, 4'd0, 1);

        do_cmd("pre1", 3'd0, 3'd0, 3'd0, 3'd1, 8'hF0, 4'd0, 0);
        do_cmd("pre2", 3'd0, 3'd0, 3'd0, 3'd2, 8'h20, 4'd0, 0);
        do_cmd("add",  3'd2, 3'd1, 3'd2, 3'd3, 8'h00, 4'd0, 0);

        do_cmd("fill_wrap", 3'd4, 3'd0, 3'd0, 3'd6, 8'h3C, 4'd4, 2);

        do_cmd("pre_c0", 3'd0, 3'd0, 3'd0, 3'd0, 8'd11, 4'd0, 0);
        do_cmd("pre_c1", 3'd0, 3'd0, 3'd0, 3'd1, 8'd22, 4'd0, 0);
        do_cmd("pre_c2", 3'd0, 3'd0, 3'd0, 3'd2, 8'd33, 4'd0, 0);
        do_cmd("pre_c3", 3'd0, 3'd0, 3'd0, 3'd3, 8'd44, 4'd0, 0);
        do_cmd("copy_ovl", 3'd3, 3'd0, 3'd0, 3'd1, 8'h00, 4'd3, 0);
        do_cmd("copy_len0", 3'd3, 3'd2, 3'd0, 3'd5, 8'h00, 4'd0, 0);
        do_cmd("copy_plain", 3'd3, 3'd5, 3'd0, 3'd2, 8'h00, 4'd3, 0);

        do_cmd("illegal6", 3'd6, 3'd1, 3'd2, 3'd3, 8'hEE, 4'd0, 5);
        do_cmd("err_clear", 3'd1, 3'd3, 3'd0, 3'd0, 8'h00, 4'd0, 0);

        do_cmd("fill_long", 3'd4, 3'd0, 3'd0, 3'd2, 8'h5A, 4'd10, 0);
        do_cmd("add_carry", 3'd2, 3'd6, 3'd7, 3'd0, 8'h00, 4'd0, 0);

        // Abort a FILL of 8 words right after its third write.
        @(negedge clk);
        wr_q.delete();
        cmd_valid = 1'b1;
        cmd_op    = 3'd4;
        cmd_a     = 3'd0;
        cmd_b     = 3'd0;
        cmd_dst   = 3'd0;
        cmd_data  = 8'hC3;
        cmd_len   = 4'd8;
        @(posedge clk);
        cyc = 0;
        while (wr_q.size() < 3 && cyc < 30) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            cyc++;
        end
        check_eq("abort_reach3", 32'(wr_q.size()), 32'd3);
        rst_n = 1'b0;
        #1;
        check_eq("abort_we_drop", 32'(write_enable), 32'd0);
        check_eq("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        for (int i = 0; i < 3; i++) exp_mem[i] = 8'hC3;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("abort_rsp_valid2", 32'(rsp_valid), 32'd0);
        check_eq("abort_wr_count", 32'(wr_q.size()), 32'd3);
        check_mem("abort");

        do_cmd("post_read", 3'd1, 3'd2, 3'd0, 3'd0, 8'h00, 4'd0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_op_sequencer.md
Name: ram_op_sequencer

Overview:
- Command-driven initiator for the team's 3-port RAM (2 asynchronous read ports, 1 synchronous write port).
- Accepts single-word and block operations over a valid/ready command channel and drives the RAM read/write ports.
- Returns one response per command over a valid/ready response channel.
- Sits between a host/CPU-side requester and the RAM instance.

Parameters:
- ADDR_WIDTH, 3, RAM address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, RAM word width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer accepts a command; high only in IDLE.
- cmd_op  in  3  opcode: 0 WRITE, 1 READ, 2 ADD, 3 COPY, 4 FILL; 5-7 illegal.
- cmd_a  in  ADDR_WIDTH  source address / operand A.
- cmd_b  in  ADDR_WIDTH  operand B (ADD only).
- cmd_dst  in  ADDR_WIDTH  destination address.
- cmd_data  in  DATA_WIDTH  write/fill data.
- cmd_len  in  ADDR_WIDTH+1  block length in words (COPY/FILL).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_data  out  DATA_WIDTH  result word.
- rsp_err  out  1  illegal opcode.
- r_addr0, r_addr1  out  ADDR_WIDTH  RAM read addresses.
- r_data0, r_data1  in  DATA_WIDTH  RAM read data, combinational from r_addr*.
- w_addr  out  ADDR_WIDTH  RAM write address.
- w_data  out  DATA_WIDTH  RAM write data.
- write_enable  out  1  RAM write strobe.

Behaviour:
- Reset (async, rst_n=0): state IDLE; write_enable=0; rsp_valid=0; rsp_data=0; rsp_err=0; all RAM addresses and w_data=0; cmd_ready=1 (decoded from IDLE).
- Reset mid-operation aborts immediately. No further writes occur. Words already written stay in RAM.
- States: IDLE -> EXEC (single ops) or LOOP (block ops) -> RESP -> IDLE.
- Handshake: a command is accepted on the edge where cmd_valid && cmd_ready. All cmd_* fields are registered then. cmd_ready=0 outside IDLE. No command queueing.
- EXEC (exactly 1 cycle):
  - r_addr0=a and r_addr1=b are driven from registered fields.
  - WRITE: write_enable=1, w_addr=dst, w_data=data; rsp_data=data.
  - READ: no write; rsp_data=r_data0.
  - ADD: write_enable=1, w_addr=dst, w_data=(r_data0+r_data1) mod 2**DATA_WIDTH, carry dropped; rsp_data=same sum.
  - Illegal opcode: no write; rsp_err=1, rsp_data=0.
- LOOP (COPY/FILL):
  - One word per cycle for len cycles. Index i runs 0..len-1.
  - COPY: r_addr0=(a+i), w_addr=(dst+i), w_data=r_data0.
  - FILL: w_addr=(dst+i), w_data=data.
  - Addresses wrap modulo depth.
  - rsp_data = len[DATA_WIDTH-1:0], zero-extended or truncated.
  - len=0: no writes; go directly to RESP.
  - len > depth is legal; addresses wrap and words are rewritten.
- COPY overlap: copy is strictly ascending. Word i is read in the cycle after word i-1 was written, so an overlap with dst = a+k (0<k<len) propagates the pattern. The bench must model this exactly.
- RESP:
  - rsp_valid=1 from the cycle after EXEC or the last LOOP cycle. Held, with stable rsp_data/rsp_err, until rsp_ready.
  - On the handshake edge: go to IDLE. rsp_valid falls and cmd_ready rises in the next cycle.
  - write_enable=0 throughout RESP and IDLE.
- Latency:
  - Single ops: accept at edge N; write at edge N+1; rsp_valid from cycle N+2.
  - Block ops: rsp_valid from cycle N+1+max(len,0)+1.
- rsp_err is cleared when the next command is accepted.

Decomposition:
- Package ram_seq_pkg: op_e enum (OP_WRITE..OP_FILL), state_e enum (IDLE, EXEC, LOOP, RESP), localparam for opcode width (3).
- No sub-module. The address/index counter stays inline.
- The bench instantiates the 3-port RAM as the slave.

Test Plan:
- WRITE dst=5 data=0xA5, then READ a=5 -> rsp_data=0xA5, rsp_err=0. write_enable high exactly 1 cycle, w_addr=5.
- Preload mem[1]=0xF0, mem[2]=0x20; ADD a=1 b=2 dst=3 -> mem[3]=0x10 (carry dropped); rsp_data=0x10.
- FILL dst=6 len=4 data=0x3C -> writes to 6,7,0,1 (wrap) on consecutive cycles; rsp_data=4. Other words unchanged.
- Preload mem[0..3]=11,22,33,44; COPY a=0 dst=1 len=3 -> mem[1..3]=11,11,11 (ascending overlap). len=0 -> no write, rsp_data=0.
- Illegal op=6 -> no write, rsp_err=1. Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable, cmd_ready=0.
- rst_n low during FILL len=8 after 3 writes -> write_enable drops immediately, only 3 words changed; after release cmd_ready=1, rsp_valid=0.
